led_pattern_engine: RTL and testbench

//   Multi-channel LED driver; generalised successor of the single fixed-rate blinker.

---
 rtl/led_pattern_engine.sv | 177 +++++++++++++++++
 tb/tb_led_pattern_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: multi-channel LED driver with per-channel OFF/ON/BLINK/PWM modes.
// A shared prescaler produces a one-clock tick every 2**PRESCALE_W clocks. A shared PWM
// phase counter advances on each tick. Channels are configured through a single write port.
// Define LED_PATTERN_BREATHE_EN to build mode 4 (BREATHE). Without it, mode 4 is rejected
// and no duty or direction registers exist.
module led_pattern_engine #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned PWM_W      = 8,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [2:0]          wr_mode,
  input  logic [PWM_W-1:0]    wr_arg,
  output logic                wr_ack,
  output logic                wr_err,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  typedef enum logic [2:0] {
    ModeOff     = 3'd0,
    ModeOn      = 3'd1,
    ModeBlink   = 3'd2,
    ModePwm     = 3'd3,
    ModeBreathe = 3'd4
  } mode_e;

  logic [PRESCALE_W-1:0] presc_q;
  logic [PWM_W-1:0]      phase_q;
  logic                  tick_q;
  logic                  ack_q;
  logic                  err_q;
  logic                  wr_valid;
  logic [CHANNELS-1:0]   led_d;
  logic [CHANNELS-1:0]   led_q;

`ifdef LED_PATTERN_BREATHE_EN
  // The phase counter moves from all-ones back to zero on this tick.
  logic phase_wrap;
  assign phase_wrap = tick_q && (phase_q == '1);
`endif

  // Classify the incoming write. An out-of-range channel or an unsupported mode is rejected.
  always_comb begin
    wr_valid = 1'b0;
    if (32'(wr_chan) < CHANNELS) begin
      wr_valid = (wr_mode <= 3'd3);
`ifdef LED_PATTERN_BREATHE_EN
      if (wr_mode == 3'd4) begin
        wr_valid = 1'b1;
      end
`endif
    end
  end

  // Shared prescaler, tick strobe, PWM phase, and write handshake pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_q <= '0;
      phase_q <= '0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_q + PRESCALE_W'(1);
      tick_q  <= (presc_q == '1);
      if (tick_q) begin
        phase_q <= phase_q + PWM_W'(1);
      end
      ack_q <= wr_en & wr_valid;
      err_q <= wr_en & ~wr_valid;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    mode_e            mode_q;
    logic [PWM_W-1:0] arg_q;
    logic [PWM_W-1:0] cnt_q;
    logic             blink_q;
    logic             wr_hit;
    logic             led_bit;

    assign wr_hit = wr_en && wr_valid && (wr_chan == CH_W'(i));

    // Channel config and blink timing. A write overrides a tick in the same cycle.
    always_ff @(posedge clock) begin
      if (!reset) begin
        mode_q  <= ModeOff;
        arg_q   <= '0;
        cnt_q   <= '0;
        blink_q <= 1'b0;
      end else if (wr_hit) begin
        mode_q  <= mode_e'(wr_mode);
        arg_q   <= wr_arg;
        cnt_q   <= '0;
        blink_q <= 1'b0;
      end else if (tick_q && (mode_q == ModeBlink)) begin
        if (cnt_q == arg_q) begin
          blink_q <= ~blink_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + PWM_W'(1);
        end
      end
    end

`ifdef LED_PATTERN_BREATHE_EN
    logic [PWM_W-1:0] duty_q;
    logic             down_q;
    logic [PWM_W:0]   duty_sum;

    assign duty_sum = {1'b0, duty_q} + {1'b0, arg_q};

    // At each phase wrap, move duty by arg and reverse direction at either end.
    always_ff @(posedge clock) begin
      if (!reset) begin
        duty_q <= '0;
        down_q <= 1'b0;
      end else if (wr_hit) begin
        duty_q <= '0;
        down_q <= 1'b0;
      end else if (phase_wrap && (mode_q == ModeBreathe)) begin
        if (!down_q) begin
          if (duty_sum >= {1'b0, {PWM_W{1'b1}}}) begin
            duty_q <= '1;
            down_q <= 1'b1;
          end else begin
            duty_q <= duty_sum[PWM_W-1:0];
          end
        end else begin
          if (duty_q <= arg_q) begin
            duty_q <= '0;
            down_q <= 1'b0;
          end else begin
            duty_q <= duty_q - arg_q;
          end
        end
      end
    end
`endif

    // Next LED level for this channel from its current mode and state.
    always_comb begin
      led_bit = 1'b0;
      case (mode_q)
        ModeOn:      led_bit = 1'b1;
        ModeBlink:   led_bit = blink_q;
        ModePwm:     led_bit = (phase_q < arg_q);
`ifdef LED_PATTERN_BREATHE_EN
        ModeBreathe: led_bit = (phase_q < duty_q);
`endif
        default:     led_bit = 1'b0;
      endcase
    end

    assign led_d[i] = led_bit;
  end

  // LED pins are registered, so they follow the channel state one clock later.
  always_ff @(posedge clock) begin
    if (!reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign wr_ack = ack_q;
  assign wr_err = err_q;
  assign tick   = tick_q;
  assign led    = led_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: scoreboard bench for led_pattern_engine.
// Configuration: PRESCALE_W=4, PWM_W=4, CHANNELS=3.
// Expected outputs come from a closed-form model based on edge counts.
module tb_led_pattern_engine;

  localparam int unsigned CHANNELS   = 3;
  localparam int unsigned PRESCALE_W = 4;
  localparam int unsigned PWM_W      = 4;
`ifdef LED_PATTERN_BREATHE_EN
  localparam bit BREATHE = 1'b1;
`else
  localparam bit BREATHE = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_chan = '0;
  logic [2:0] wr_mode = '0;
  logic [3:0] wr_arg = '0;
  logic       wr_ack;
  logic       wr_err;
  logic       tick;
  logic [2:0] led;

  led_pattern_engine #(
    .CHANNELS  (CHANNELS),
    .PRESCALE_W(PRESCALE_W),
    .PWM_W     (PWM_W)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_chan(wr_chan),
    .wr_mode(wr_mode),
    .wr_arg (wr_arg),
    .wr_ack (wr_ack),
    .wr_err (wr_err),
    .tick   (tick),
    .led    (led)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       tick;
    logic       ack;
    logic       err;
    logic [2:0] led;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k        = 0;  // index of the next edge, counted from the first edge after reset release
  int   m_mode[3];
  int   m_arg[3];
  int   m_w[3];      // edge at which the channel was last written

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, k - 1, obs, exp);
    end
  endtask

  // Return the LED level implied by channel c's state after edge m.
  // Tick edges are the multiples of 16 above zero. Phase wraps happen at multiples of 256.
  function automatic bit model_led(input int c, input int m);
    int ticks;
    int wraps;
    int duty;
    bit down;
    case (m_mode[c])
      1: return 1'b1;
      2: begin
        ticks = m / 16 - m_w[c] / 16;
        return ((ticks / (m_arg[c] + 1)) % 2) == 1;
      end
      3: return ((m / 16) % 16) < m_arg[c];
      4: begin
        wraps = m / 256 - m_w[c] / 256;
        duty  = 0;
        down  = 1'b0;
        for (int s = 0; s < wraps; s++) begin
          if (!down) begin
            duty = duty + m_arg[c];
            if (duty >= 15) begin
              duty = 15;
              down = 1'b1;
            end
          end else begin
            duty = duty - m_arg[c];
            if (duty <= 0) begin
              duty = 0;
              down = 1'b0;
            end
          end
        end
        return ((m / 16) % 16) < duty;
      end
      default: return 1'b0;
    endcase
  endfunction

  // Drive one clock of stimulus, queue its expected outputs, then compare after the edge.
  task automatic cycle(input bit en, input int chan, input int mode, input int arg);
    exp_t e;
    exp_t got;
    bit   valid;
    wr_en   = en;
    wr_chan = chan[1:0];
    wr_mode = mode[2:0];
    wr_arg  = arg[3:0];
    e = '0;
    if (reset) begin
      valid  = en && (chan < 3) && ((mode <= 3) || (BREATHE && (mode == 4)));
      e.tick = ((k % 16) == 15);
      e.ack  = valid;
      e.err  = en && !valid;
      for (int c = 0; c < 3; c++) begin
        e.led[c] = model_led(c, k - 1);
      end
      if (valid) begin
        m_mode[chan] = mode;
        m_arg[chan]  = arg;
        m_w[chan]    = k;
      end
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (reset) begin
      k++;
    end
    got = exp_q.pop_front();
    check("tick", {7'b0, tick}, {7'b0, got.tick});
    check("wr_ack", {7'b0, wr_ack}, {7'b0, got.ack});
    check("wr_err", {7'b0, wr_err}, {7'b0, got.err});
    check("led", {5'b0, led}, {5'b0, got.led});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 0, 0, 0);
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      m_mode[c] = 0;
      m_arg[c]  = 0;
      m_w[c]    = 0;
    end
    // Hold reset with write strobes toggling. The writes must be ignored.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(i[0], 1, 1, 0);
    end
    reset = 1'b1;
    idle(40);
    // ch1 ON, then OFF
    cycle(1'b1, 1, 1, 0);
    idle(3);
    cycle(1'b1, 1, 0, 0);
    idle(3);
    // ch0 BLINK arg=2
    cycle(1'b1, 0, 2, 2);
    idle(160);
    // Rewrite ch0 BLINK in the same cycle as a tick. The count clears and no toggle happens.
    while ((k % 16) != 0) begin
      idle(1);
    end
    cycle(1'b1, 0, 2, 2);
    idle(100);
    // ch2 PWM arg=5, then arg=0, then arg=15
    cycle(1'b1, 2, 3, 5);
    idle(260);
    cycle(1'b1, 2, 3, 0);
    idle(40);
    cycle(1'b1, 2, 3, 15);
    idle(280);
    // Rejected writes: bad channel, bad mode, and mode 4 (accepted only when built in)
    cycle(1'b1, 3, 1, 0);
    idle(1);
    cycle(1'b1, 0, 5, 7);
    idle(1);
    cycle(1'b1, 1, 4, 4);
    idle(1);
    // Back-to-back writes, one of them rejected
    cycle(1'b1, 0, 1, 0);
    cycle(1'b1, 3, 1, 0);
    cycle(1'b1, 1, 1, 0);
    cycle(1'b1, 2, 0, 0);
    cycle(1'b1, 0, 0, 0);
    idle(4);
`ifdef LED_PATTERN_BREATHE_EN
    // BREATHE arg=4 over ten phase wraps
    cycle(1'b1, 1, 4, 4);
    idle(256 * 10);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
